// File: rtl/multicycle_control_32.sv
// multicycle_control_32
// Multi-cycle MIPS main control FSM. Walks FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK for r_type, lw, sw, beq, addi and j and drives the datapath
// strobes for the shared-memory multi-cycle datapath.
// Memory-access states (FETCH, MEM_READ, MEM_WRITE) are each held for
// MEM_LATENCY cycles using an internal wait counter.
// Optional build macro: CTRL_BNE_EN adds bne (opcode 000101) and the
// branch_ne output that tells the datapath to qualify the branch with ~zero.
module multicycle_control_32 #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4,
  parameter int ALU_OP_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [5:0]          opcode,
  output logic                busy,
  output logic                finish,
  output logic                err_illegal_opcode,
`ifdef CTRL_BNE_EN
  output logic                branch_ne,
`endif
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_toreg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = '0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

  // Last counter value of a memory-access state; the state exits here.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    R_WB,
    EXEC_I,
    I_WB,
    BRANCH,
    JUMP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       op_q;
  logic             err_q;
  logic             cnt_last;

  // Opcodes the sequencer knows how to execute.
  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef CTRL_BNE_EN
      OP_BNE: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign cnt_last = (cnt == CNT_LAST);

  // State register, memory-wait counter, latched opcode and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= FETCH;
            err_q <= 1'b0;
          end
        end
        FETCH: begin
          if (cnt_last) begin
            state <= DECODE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DECODE: begin
          // Later states sequence from this copy, not the live opcode.
          op_q <= opcode;
          cnt  <= '0;
          case (opcode)
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_RTYPE:     state <= EXEC_R;
            OP_ADDI:      state <= EXEC_I;
            OP_BEQ:       state <= BRANCH;
`ifdef CTRL_BNE_EN
            OP_BNE:       state <= BRANCH;
`endif
            OP_J:         state <= JUMP;
            default: begin
              state <= IDLE;
              err_q <= 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          cnt   <= '0;
          state <= (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          if (cnt_last) begin
            state <= MEM_WB;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MEM_WRITE: begin
          if (cnt_last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EXEC_R: begin
          cnt   <= '0;
          state <= R_WB;
        end
        EXEC_I: begin
          cnt   <= '0;
          state <= I_WB;
        end
        MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign err_illegal_opcode = err_q;

  // Moore decode of datapath strobes from the current state.
  always_comb begin
    busy          = (state != IDLE);
    finish        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_toreg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = cnt_last;
        pc_write  = cnt_last;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        finish    = ~is_legal(opcode);
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_toreg = 1'b1;
        finish    = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        finish    = cnt_last;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        finish    = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      I_WB: begin
        reg_write = 1'b1;
        finish    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        finish        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        finish    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_BNE_EN
  // Branch sense flag; only meaningful while BRANCH is active.
  always_comb begin
    branch_ne = (state == BRANCH) && (op_q == OP_BNE);
  end
`endif

endmodule

// File: tb/tb_multicycle_control_32.sv
// Bench for multicycle_control_32: two instances (MEM_LATENCY 1 and 3),
// per-cycle expected output words queued by a spec model and compared
// against the DUT on the falling edge.
module tb_multicycle_control_32;

  localparam int LA = 1;
  localparam int LB = 3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       bne;
    logic       busy;
    logic       finish;
    logic       err;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_toreg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ow_t;

  typedef struct {
    int         inst;
    logic [5:0] op;
    int         busy_cycles;
    bit         poke;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_s[2];
  logic [5:0] opc_s[2];
  logic       d_busy[2], d_finish[2], d_err[2], d_pcw[2], d_pcwc[2];
  logic [1:0] d_pcsrc[2];
  logic       d_iord[2], d_mr[2], d_mw[2], d_irw[2], d_m2r[2], d_rdst[2], d_rw[2], d_asa[2];
  logic [1:0] d_asb[2];
  logic [1:0] d_aop[2];
  logic       d_bne[2];

`ifndef CTRL_BNE_EN
  assign d_bne[0] = 1'b0;
  assign d_bne[1] = 1'b0;
`endif

  multicycle_control_32 #(.MEM_LATENCY(LA), .CNT_W(4), .ALU_OP_W(2)) u_a (
    .clk(clk), .reset(reset), .start(start_s[0]), .opcode(opc_s[0]),
    .busy(d_busy[0]), .finish(d_finish[0]), .err_illegal_opcode(d_err[0]),
`ifdef CTRL_BNE_EN
    .branch_ne(d_bne[0]),
`endif
    .pc_write(d_pcw[0]), .pc_write_cond(d_pcwc[0]), .pc_source(d_pcsrc[0]),
    .i_or_d(d_iord[0]), .mem_read(d_mr[0]), .mem_write(d_mw[0]), .ir_write(d_irw[0]),
    .mem_toreg(d_m2r[0]), .reg_dst(d_rdst[0]), .reg_write(d_rw[0]),
    .alu_src_a(d_asa[0]), .alu_src_b(d_asb[0]), .alu_op(d_aop[0])
  );

  multicycle_control_32 #(.MEM_LATENCY(LB), .CNT_W(4), .ALU_OP_W(2)) u_b (
    .clk(clk), .reset(reset), .start(start_s[1]), .opcode(opc_s[1]),
    .busy(d_busy[1]), .finish(d_finish[1]), .err_illegal_opcode(d_err[1]),
`ifdef CTRL_BNE_EN
    .branch_ne(d_bne[1]),
`endif
    .pc_write(d_pcw[1]), .pc_write_cond(d_pcwc[1]), .pc_source(d_pcsrc[1]),
    .i_or_d(d_iord[1]), .mem_read(d_mr[1]), .mem_write(d_mw[1]), .ir_write(d_irw[1]),
    .mem_toreg(d_m2r[1]), .reg_dst(d_rdst[1]), .reg_write(d_rw[1]),
    .alu_src_a(d_asa[1]), .alu_src_b(d_asb[1]), .alu_op(d_aop[1])
  );

  ow_t q0[$];
  ow_t q1[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  busy_cnt[2];
  int  fin_cnt[2];
  logic idle_err[2];
  bit  chk_en = 1'b0;

  function automatic ow_t actual(input int i);
    ow_t w;
    w.bne = d_bne[i];           w.busy = d_busy[i];       w.finish = d_finish[i];
    w.err = d_err[i];           w.pc_write = d_pcw[i];    w.pc_write_cond = d_pcwc[i];
    w.pc_source = d_pcsrc[i];   w.i_or_d = d_iord[i];     w.mem_read = d_mr[i];
    w.mem_write = d_mw[i];      w.ir_write = d_irw[i];    w.mem_toreg = d_m2r[i];
    w.reg_dst = d_rdst[i];      w.reg_write = d_rw[i];    w.alu_src_a = d_asa[i];
    w.alu_src_b = d_asb[i];     w.alu_op = d_aop[i];
    return w;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    bit ok;
    ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
         (op == OP_ADDI) || (op == OP_J);
`ifdef CTRL_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

  task automatic push(input int i, input ow_t w);
    if (i == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Spec model: one expected output word per cycle after acceptance,
  // followed by the idle word the controller settles to.
  task automatic push_instr(input int i, input logic [5:0] op, input int L);
    ow_t w;
    for (int k = 0; k < L; k++) begin
      w = '0; w.busy = 1; w.mem_read = 1; w.alu_src_b = 2'b01;
      w.ir_write = (k == L - 1); w.pc_write = (k == L - 1);
      push(i, w);
    end
    w = '0; w.busy = 1; w.alu_src_b = 2'b11; w.finish = !legal(op);
    push(i, w);
    if (!legal(op)) begin
      w = '0; w.err = 1; push(i, w);
      return;
    end
    if (op == OP_LW || op == OP_SW) begin
      w = '0; w.busy = 1; w.alu_src_a = 1; w.alu_src_b = 2'b10; push(i, w);
      for (int k = 0; k < L; k++) begin
        w = '0; w.busy = 1; w.i_or_d = 1;
        if (op == OP_LW) w.mem_read = 1;
        else begin w.mem_write = 1; w.finish = (k == L - 1); end
        push(i, w);
      end
      if (op == OP_LW) begin
        w = '0; w.busy = 1; w.reg_write = 1; w.mem_toreg = 1; w.finish = 1; push(i, w);
      end
    end else if (op == OP_R) begin
      w = '0; w.busy = 1; w.alu_src_a = 1; w.alu_op = 2'd2; push(i, w);
      w = '0; w.busy = 1; w.reg_write = 1; w.reg_dst = 1; w.finish = 1; push(i, w);
    end else if (op == OP_ADDI) begin
      w = '0; w.busy = 1; w.alu_src_a = 1; w.alu_src_b = 2'b10; push(i, w);
      w = '0; w.busy = 1; w.reg_write = 1; w.finish = 1; push(i, w);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      w = '0; w.busy = 1; w.alu_src_a = 1; w.alu_op = 2'd1; w.pc_write_cond = 1;
      w.pc_source = 2'b01; w.finish = 1; w.bne = (op == OP_BNE); push(i, w);
    end else begin
      w = '0; w.busy = 1; w.pc_write = 1; w.pc_source = 2'b10; w.finish = 1; push(i, w);
    end
    w = '0; push(i, w);
  endtask

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        ow_t e;
        ow_t a;
        a = actual(i);
        if (i == 0 && q0.size() > 0)      e = q0.pop_front();
        else if (i == 1 && q1.size() > 0) e = q1.pop_front();
        else begin e = '0; e.err = idle_err[i]; end
        if (!e.busy) idle_err[i] = e.err;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs inst%0d t=%0t got %h expected %h", i, $time, a, e);
        end
        if (a.busy === 1'b1)   busy_cnt[i]++;
        if (a.finish === 1'b1) fin_cnt[i]++;
      end
    end
  end

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (qsize(i) > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout inst%0d got queue %0d required 0", i, qsize(i));
    end
    #1;
  endtask

  task automatic run(input int i, input logic [5:0] op, input bit poke);
    int L;
    L = (i == 0) ? LA : LB;
    @(posedge clk); #1;
    start_s[i] = 1'b1; opc_s[i] = op;
    @(posedge clk); #1;
    start_s[i] = poke;
    push_instr(i, op, L);
    repeat (L + 1) @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    opc_s[i] = ~op;
    wait_idle(i);
  endtask

  vec_t tbl[14];

  initial begin
    int b0, f0;
    tbl[0]  = '{0, OP_R,    LA + 3,     1'b0};
    tbl[1]  = '{0, OP_ADDI, LA + 3,     1'b0};
    tbl[2]  = '{0, OP_BEQ,  LA + 2,     1'b0};
    tbl[3]  = '{0, OP_BAD,  LA + 1,     1'b0};
    tbl[4]  = '{0, OP_J,    LA + 2,     1'b0};
    tbl[5]  = '{1, OP_LW,   2 * LB + 3, 1'b0};
    tbl[6]  = '{1, OP_SW,   2 * LB + 2, 1'b1};
    tbl[7]  = '{1, OP_R,    LB + 3,     1'b0};
    tbl[8]  = '{1, OP_BAD,  LB + 1,     1'b0};
    tbl[9]  = '{1, OP_J,    LB + 2,     1'b0};
    tbl[10] = '{1, OP_BEQ,  LB + 2,     1'b0};
    tbl[11] = '{0, 6'b000001, LA + 1,   1'b0};
    tbl[12] = '{1, OP_SW,   2 * LB + 2, 1'b0};
`ifdef CTRL_BNE_EN
    tbl[13] = '{0, OP_BNE,  LA + 2,     1'b0};
`else
    tbl[13] = '{0, OP_BNE,  LA + 1,     1'b0};
`endif

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; opc_s[i] = '0;
      busy_cnt[i] = 0; fin_cnt[i] = 0; idle_err[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 14; v++) begin
      b0 = busy_cnt[tbl[v].inst];
      f0 = fin_cnt[tbl[v].inst];
      run(tbl[v].inst, tbl[v].op, tbl[v].poke);
      vectors++;
      if (busy_cnt[tbl[v].inst] - b0 != tbl[v].busy_cycles) begin
        miscompares++;
        $display("FAIL busy_len vec%0d got %0d required %0d", v,
                 busy_cnt[tbl[v].inst] - b0, tbl[v].busy_cycles);
      end
      vectors++;
      if (fin_cnt[tbl[v].inst] - f0 != 1) begin
        miscompares++;
        $display("FAIL finish_count vec%0d got %0d required 1", v, fin_cnt[tbl[v].inst] - f0);
      end
    end

    // Leave an error flag set on the fast instance, then reset the slow one mid-lw.
    run(0, OP_BAD, 1'b0);
    @(posedge clk); #1;
    start_s[1] = 1'b1; opc_s[1] = OP_LW;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    push_instr(1, OP_LW, LB);
    f0 = fin_cnt[1];
    b0 = busy_cnt[1];
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q1.delete();
    idle_err[0] = 1'b0;
    idle_err[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (fin_cnt[1] != f0) begin
      miscompares++;
      $display("FAIL reset_no_finish got %0d required %0d", fin_cnt[1], f0);
    end
    vectors++;
    if (busy_cnt[1] - b0 != LB + 3) begin
      miscompares++;
      $display("FAIL reset_busy_len got %0d required %0d", busy_cnt[1] - b0, LB + 3);
    end

    // Controller must be usable straight after the abort.
    run(1, OP_ADDI, 1'b0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_32.md
Name: multicycle_control_32

Overview:
- Clocked multi-cycle successor to the single-cycle MIPS main decoder.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states for r_type, lw, sw, beq, addi and j, with per-state datapath strobes.
- Supports a parametrised memory wait latency and a start/finish handshake.
- Sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath.

Parameters:
- MEM_LATENCY, 1: cycles each memory-access state is held (FETCH, MEM_READ, MEM_WRITE); legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the internal memory-wait counter.
- ALU_OP_W, 2: alu_op width, minimum 2. Codes are add=0, sub=1, funct=2, zero-extended.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request one instruction; sampled only in IDLE
- opcode  in  6  IR[31:26]; valid from DECODE onward
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle pulse in the final cycle of an instruction
- err_illegal_opcode  out  1  sticky illegal-opcode flag
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs)
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- mem_toreg  out  1  register write data: 1 MDR, 0 ALUOut
- reg_dst  out  1  register destination: 1 rd, 0 rt
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs
- alu_src_b  out  2  ALU B input: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  ALU_OP_W  ALU operation code

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE and the wait counter to 0.
  - Every output is 0, including err_illegal_opcode.
  - Reset mid-instruction aborts the instruction with no finish pulse. Reset has priority over all other events.
- Outputs are decoded from the state register (Moore). Exceptions: ir_write and pc_write in FETCH also depend on the counter. Any strobe not listed below is 0 in that state.
- IDLE:
  - start=1 goes to FETCH, clears err_illegal_opcode and clears the counter.
  - start=0 holds IDLE.
  - start asserted while busy is ignored; it is not queued.
- FETCH (MEM_LATENCY cycles):
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add.
  - ir_write=1 and pc_write=1 (pc_source=00) only in the last cycle, i.e. counter==MEM_LATENCY-1. Then go to DECODE.
- DECODE (1 cycle):
  - alu_src_a=0, alu_src_b=11, alu_op=add.
  - Next state by opcode: lw/sw -> MEM_ADDR; r_type -> EXEC_R; addi -> EXEC_I; beq -> BRANCH; j -> JUMP.
  - Any other opcode: finish=1 this cycle, err_illegal_opcode set next edge, return to IDLE.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEM_READ; sw -> MEM_WRITE.
  - The opcode is latched internally in DECODE, so later input changes do not affect sequencing.
- MEM_READ (MEM_LATENCY cycles): mem_read=1, i_or_d=1. Then go to MEM_WB.
- MEM_WB: reg_write=1, mem_toreg=1, reg_dst=0, finish=1. Then go to IDLE.
- MEM_WRITE (MEM_LATENCY cycles): mem_write=1, i_or_d=1. finish=1 in the last cycle, then go to IDLE.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=funct. Then go to R_WB.
- R_WB: reg_write=1, reg_dst=1, finish=1. Then go to IDLE.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=add. Then go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_toreg=0, finish=1. Then go to IDLE.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01, finish=1. Then go to IDLE.
- JUMP: pc_write=1, pc_source=10, finish=1. Then go to IDLE.
- Wait counter:
  - Counts 0..MEM_LATENCY-1 inside multi-cycle states and clears on every state change.
  - Never wraps: the state exits at MEM_LATENCY-1.
- Busy cycles (start accepted at edge 0, L=MEM_LATENCY):
  - r_type: L+3
  - lw: 2L+3
  - sw: 2L+2
  - addi: L+3
  - beq: L+2
  - j: L+2
  - illegal: L+1
- finish pulses exactly once per accepted start. busy falls the cycle after finish.

Optional Feature:
- Macro: CTRL_BNE_EN.
- Defined: opcode 6'b000101 (bne) is legal.
  - DECODE goes to BRANCH. BRANCH drives the same strobes as beq.
  - An extra output port branch_ne (1 bit) is 1 only in BRANCH for bne, so the datapath qualifies with ~zero.
  - branch_ne resets to 0.
- Undefined: the port is absent and bne is illegal, per the DECODE rule.

Test Plan:
- MEM_LATENCY=1:
  - reset, start=1, opcode=000000 -> busy 4 cycles.
  - Sequence FETCH, DECODE, EXEC_R, R_WB.
  - reg_write=1 and reg_dst=1 in cycle 4 with finish=1.
  - Then all outputs 0.
- MEM_LATENCY=3, lw (100011):
  - busy 9 cycles.
  - mem_read high cycles 1-3 (i_or_d=0) and cycles 6-8 (i_or_d=1).
  - ir_write only in cycle 3.
  - finish with mem_toreg=1 in cycle 9.
- Illegal opcode 111111:
  - finish in cycle L+1, err_illegal_opcode=1 afterwards.
  - A following start with opcode 000010 clears err at acceptance and ends with pc_write=1, pc_source=10 in JUMP.
- Re-assert start during sw -> ignored; exactly one finish observed.
- Reset asserted in MEM_READ of lw -> next cycle busy=0, no finish, all strobes 0.
- beq (000100) -> BRANCH with pc_write_cond=1, alu_op=1, pc_source=01.
  - With CTRL_BNE_EN and opcode 000101: same strobes plus branch_ne=1.
